// File: rtl/lm07_frame_decode.sv
// lm07_frame_decode: captures LM07-style serial temperature frames (MSB first,
// sampled on SCK rising edges while CS is low) and publishes the 11-bit signed
// reading on TEMP with a one-cycle TEMP_VALID strobe. A frame whose SCK edge
// count differs from FRAME_BITS produces a one-cycle FRAME_ERR strobe instead.
//
// Optional feature: define LM07_ALARM_EN to add the ALARM output, a
// hysteretic over-temperature flag (set above T_HIGH, cleared below T_LOW).
//
// CS and SCK are already in the SYSCLK domain. Both are registered once
// (cs_q, sck_q). The FSM reacts to cs_q, so a CS change reaches the FSM one
// cycle after it is sampled. That delay lets a CS fall that lands during DONE
// still be seen by the following IDLE cycle.
module lm07_frame_decode #(
    parameter int                 FRAME_BITS = 16,
    parameter logic signed [10:0] T_HIGH     = 11'sd120,
    parameter logic signed [10:0] T_LOW      = 11'sd112
) (
    input  logic        SYSCLK,
    input  logic        RSTN,
    input  logic        CS,
    input  logic        SCK,
    input  logic        SIO,
    output logic [10:0] TEMP,
    output logic        TEMP_VALID,
    output logic        FRAME_ERR
`ifdef LM07_ALARM_EN
    ,
    output logic        ALARM
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    state_t      state_q, state_d;
    logic        cs_q;
    logic        sck_q;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic [10:0] temp_q;
    logic        valid_q;
    logic        err_q;

    logic        sck_edge;
    logic        shift_clr;
    logic        shift_en;
    logic        load;
    logic        bad_len;

    // An SCK rising edge counts only while the sensor is selected.
    assign sck_edge = SCK & ~sck_q & ~CS;

    // State register.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state. A low cs_q in IDLE, or a high cs_q in SHIFT, marks a CS edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_q) state_d = SHIFT;
            SHIFT:   if (cs_q)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes decoded from the current state.
    always_comb begin
        shift_clr = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        bad_len   = 1'b0;
        case (state_q)
            IDLE:    shift_clr = ~cs_q;
            SHIFT:   shift_en  = sck_edge;
            DONE: begin
                load    = (cnt_q == FRAME_CNT);
                bad_len = (cnt_q != FRAME_CNT);
            end
            default: ;
        endcase
    end

    // Input delay registers used for edge detection.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cs_q  <= 1'b1;
            sck_q <= 1'b0;
        end else begin
            cs_q  <= CS;
            sck_q <= SCK;
        end
    end

    // Shift register and saturating bit counter. Both are cleared on the way into SHIFT.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            shift_q <= 16'd0;
            cnt_q   <= 5'd0;
        end else if (shift_clr) begin
            shift_q <= 16'd0;
            cnt_q   <= 5'd0;
        end else if (shift_en) begin
            shift_q <= {shift_q[14:0], SIO};
            if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
        end
    end

    // Result registers. TEMP holds across bad frames; the strobes last one cycle.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            temp_q  <= 11'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= load;
            err_q   <= bad_len;
            if (load) temp_q <= shift_q[15:5];
        end
    end

    assign TEMP       = temp_q;
    assign TEMP_VALID = valid_q;
    assign FRAME_ERR  = err_q;

`ifdef LM07_ALARM_EN
    logic               alarm_q;
    logic signed [10:0] new_temp;

    assign new_temp = signed'(shift_q[15:5]);

    // Hysteretic alarm, updated together with TEMP from the incoming reading.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            alarm_q <= 1'b0;
        end else if (load) begin
            if (new_temp > T_HIGH)     alarm_q <= 1'b1;
            else if (new_temp < T_LOW) alarm_q <= 1'b0;
        end
    end

    assign ALARM = alarm_q;
`endif

endmodule

// File: tb/tb_lm07_frame_decode.sv
// Directed testbench for lm07_frame_decode. Frames are bit-banged with SCK at
// a quarter of SYSCLK, and the outputs are sampled on the falling SYSCLK edge.
module tb_lm07_frame_decode;

    logic        SYSCLK = 1'b0;
    logic        RSTN   = 1'b0;
    logic        CS     = 1'b1;
    logic        SCK    = 1'b0;
    logic        SIO    = 1'b0;
    logic [10:0] TEMP;
    logic        TEMP_VALID;
    logic        FRAME_ERR;
`ifdef LM07_ALARM_EN
    logic        ALARM;
`endif

    int total = 0;
    int bad   = 0;
    int both_cnt = 0;
    logic [10:0] vq[$];

    always #5 SYSCLK = ~SYSCLK;

    lm07_frame_decode dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .CS         (CS),
        .SCK        (SCK),
        .SIO        (SIO),
        .TEMP       (TEMP),
        .TEMP_VALID (TEMP_VALID),
        .FRAME_ERR  (FRAME_ERR)
`ifdef LM07_ALARM_EN
        ,
        .ALARM      (ALARM)
`endif
    );

    // Record every published reading, and flag any cycle with both strobes high.
    always @(negedge SYSCLK) begin
        if (TEMP_VALID) vq.push_back(TEMP);
        if (TEMP_VALID && FRAME_ERR) both_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    // Pull CS low and clock out the top n bits of d, MSB first.
    task automatic drive_bits(input logic [15:0] d, input int n);
        CS = 1'b0;
        cyc(4);
        for (int i = 0; i < n; i++) begin
            SIO = d[15-i];
            SCK = 1'b1;
            cyc(2);
            SCK = 1'b0;
            cyc(2);
        end
    endtask

    // Raise CS, then find which falling edge (1..8) shows each strobe.
    task automatic end_frame(output int vpos, output int epos,
                             output int vcnt, output int ecnt);
        vpos = 0; epos = 0; vcnt = 0; ecnt = 0;
        CS = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge SYSCLK);
            if (TEMP_VALID) begin vcnt++; if (vpos == 0) vpos = i; end
            if (FRAME_ERR)  begin ecnt++; if (epos == 0) epos = i; end
        end
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(2);
        total++; if (TEMP !== 11'd0)     begin bad++; $display("FAIL rst_temp got=%h exp=000", TEMP); end
        total++; if (TEMP_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", TEMP_VALID); end
        total++; if (FRAME_ERR !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", FRAME_ERR); end
`ifdef LM07_ALARM_EN
        total++; if (ALARM !== 1'b0)      begin bad++; $display("FAIL rst_alarm got=%b exp=0", ALARM); end
`endif
        RSTN = 1'b1;
        cyc(2);
    endtask

    // Good frame: one TEMP_VALID on the 4th falling edge after CS is raised.
    task automatic test_frame(input string nm, input logic [15:0] d, input logic [10:0] exp);
        int vp, ep, vc, ec;
        drive_bits(d, 16);
        end_frame(vp, ep, vc, ec);
        total++; if (vc !== 1)     begin bad++; $display("FAIL %s_vcnt got=%0d exp=1", nm, vc); end
        total++; if (vp !== 4)     begin bad++; $display("FAIL %s_latency got=%0d exp=4", nm, vp); end
        total++; if (ec !== 0)     begin bad++; $display("FAIL %s_err got=%0d exp=0", nm, ec); end
        total++; if (TEMP !== exp) begin bad++; $display("FAIL %s_temp got=%h exp=%h", nm, TEMP, exp); end
    endtask

    task automatic test_bad_count();
        int vp, ep, vc, ec;
        drive_bits(16'h1234, 10);
        end_frame(vp, ep, vc, ec);
        total++; if (ec !== 1)        begin bad++; $display("FAIL short_ecnt got=%0d exp=1", ec); end
        total++; if (ep !== 4)        begin bad++; $display("FAIL short_epos got=%0d exp=4", ep); end
        total++; if (vc !== 0)        begin bad++; $display("FAIL short_vcnt got=%0d exp=0", vc); end
        total++; if (TEMP !== 11'h7FB) begin bad++; $display("FAIL short_temp got=%h exp=7fb", TEMP); end
    endtask

    task automatic test_reset_mid();
        drive_bits(16'hABCD, 8);
        RSTN = 1'b0;
        #1;
        total++; if (TEMP !== 11'd0)      begin bad++; $display("FAIL midrst_temp got=%h exp=000", TEMP); end
        total++; if (TEMP_VALID !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", TEMP_VALID); end
        total++; if (FRAME_ERR !== 1'b0)  begin bad++; $display("FAIL midrst_err got=%b exp=0", FRAME_ERR); end
        CS = 1'b1;
        cyc(2);
        RSTN = 1'b1;
        cyc(2);
        test_frame("after_rst", 16'h0C80, 11'h064);
    endtask

    task automatic test_back_to_back();
        int vp, ep, vc, ec;
        cyc(4);
        vq.delete();
        drive_bits(16'h0C80, 16);
        CS = 1'b1;
        cyc(1);
        drive_bits(16'h1900, 16);
        end_frame(vp, ep, vc, ec);
        cyc(2);
        total++;
        if (vq.size() !== 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", vq.size());
        end else begin
            total++; if (vq[0] !== 11'h064) begin bad++; $display("FAIL b2b_first got=%h exp=064", vq[0]); end
            total++; if (vq[1] !== 11'h0C8) begin bad++; $display("FAIL b2b_second got=%h exp=0c8", vq[1]); end
        end
    endtask

`ifdef LM07_ALARM_EN
    task automatic test_alarm();
        logic [15:0] fr [3] = '{16'h0F80, 16'h0E80, 16'h0DE0};
        logic [10:0] tv [3] = '{11'd124, 11'd116, 11'd111};
        logic        av [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            test_frame("alarm_frame", fr[i], tv[i]);
            total++; if (ALARM !== av[i]) begin bad++; $display("FAIL alarm_%0d got=%b exp=%b", i, ALARM, av[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame("pos25", 16'h0C80, 11'h064);
        test_frame("neg1p25", 16'hFF60, 11'h7FB);
        test_bad_count();
        test_reset_mid();
        test_back_to_back();
`ifdef LM07_ALARM_EN
        test_alarm();
`endif
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
